// File: rtl/pipe_rd_tracker.sv
// Destination-register tracker for EX/MEM/WB with load-use stall sequencing.
// Define STALL_STATS_EN to add a saturating stall_count output.
module pipe_rd_tracker #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_valid,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic             d_uses_rt,
  input  logic [REG_W-1:0] d_rd,
  input  logic             d_regwrite,
  input  logic             d_memread,
  input  logic             flush_x,
  output logic [REG_W-1:0] x_rd,
  output logic [REG_W-1:0] x_rt,
  output logic             x_valid,
  output logic [REG_W-1:0] m_rd,
  output logic             m_valid,
  output logic [REG_W-1:0] w_rd,
  output logic             w_regwrite,
  output logic             stall_req
`ifdef STALL_STATS_EN
  ,output logic [15:0]     stall_count
`endif
);

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rt;
    logic             rw;
    logic             mr;
  } ex_t;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             rw;
  } wb_t;

  typedef enum logic {RUN, STALL} st_e;

  ex_t        x_q, x_d;
  wb_t        m_q, w_q;
  st_e        st_q;
  logic [2:0] cnt_q;
  logic       hz;

  assign hz = d_valid & x_q.v & x_q.mr & (x_q.rd != '0)
            & ((x_q.rd == d_rs) | (d_uses_rt & (x_q.rd == d_rt)));

  assign stall_req = (st_q == STALL) ? ~flush_x : (hz & ~flush_x);

  // $zero is captured as non-writing so it never looks like a source
  always_comb begin
    x_d = '0;
    if (d_valid & ~flush_x & ~stall_req) begin
      x_d.v  = 1'b1;
      x_d.rd = d_rd;
      x_d.rt = d_rt;
      x_d.rw = d_regwrite & (d_rd != '0);
      x_d.mr = d_memread;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      x_q <= x_d;
      m_q <= '{v: x_q.v, rd: x_q.rd, rw: x_q.rw};
      w_q <= m_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= RUN;
      cnt_q <= '0;
    end else begin
      unique case (st_q)
        RUN: begin
          if (stall_req && LOAD_LAT > 1) begin
            st_q  <= STALL;
            cnt_q <= 3'(LOAD_LAT - 1);
          end
        end
        STALL: begin
          if (flush_x || cnt_q == 3'd1) begin
            st_q  <= RUN;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
      endcase
    end
  end

  assign x_valid    = x_q.v;
  assign x_rd       = (x_q.v & x_q.rw) ? x_q.rd : '0;
  assign x_rt       = x_q.v ? x_q.rt : '0;
  assign m_valid    = m_q.v;
  assign m_rd       = (m_q.v & m_q.rw) ? m_q.rd : '0;
  assign w_rd       = (w_q.v & w_q.rw) ? w_q.rd : '0;
  assign w_regwrite = w_q.v & w_q.rw;

`ifdef STALL_STATS_EN
  logic [15:0] stat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else if (stall_req && stat_q != 16'hFFFF) begin
      stat_q <= stat_q + 16'd1;
    end
  end

  assign stall_count = stat_q;
`endif

endmodule

// File: tb/tb_pipe_rd_tracker.sv
// Bench for pipe_rd_tracker: directed vector table plus randomized
// stimulus against a slot-list reference model, LOAD_LAT=1 and 3.
module tb_pipe_rd_tracker;

  logic       clk;
  logic       rst_n;
  logic       d_valid, d_uses_rt, d_regwrite, d_memread, flush_x;
  logic [4:0] d_rs, d_rt, d_rd;

  logic [4:0] x_rd_w [2];
  logic [4:0] x_rt_w [2];
  logic [4:0] m_rd_w [2];
  logic [4:0] w_rd_w [2];
  logic       x_v_w  [2];
  logic       m_v_w  [2];
  logic       w_rw_w [2];
  logic       stl_w  [2];
`ifdef STALL_STATS_EN
  logic [15:0] scnt_w [2];
`endif

  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_rd_tracker #(.REG_W(5), .LOAD_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rs(d_rs),
    .d_rt(d_rt), .d_uses_rt(d_uses_rt), .d_rd(d_rd),
    .d_regwrite(d_regwrite), .d_memread(d_memread), .flush_x(flush_x),
    .x_rd(x_rd_w[0]), .x_rt(x_rt_w[0]), .x_valid(x_v_w[0]),
    .m_rd(m_rd_w[0]), .m_valid(m_v_w[0]), .w_rd(w_rd_w[0]),
    .w_regwrite(w_rw_w[0]), .stall_req(stl_w[0])
`ifdef STALL_STATS_EN
    , .stall_count(scnt_w[0])
`endif
  );

  pipe_rd_tracker #(.REG_W(5), .LOAD_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rs(d_rs),
    .d_rt(d_rt), .d_uses_rt(d_uses_rt), .d_rd(d_rd),
    .d_regwrite(d_regwrite), .d_memread(d_memread), .flush_x(flush_x),
    .x_rd(x_rd_w[1]), .x_rt(x_rt_w[1]), .x_valid(x_v_w[1]),
    .m_rd(m_rd_w[1]), .m_valid(m_v_w[1]), .w_rd(w_rd_w[1]),
    .w_regwrite(w_rw_w[1]), .stall_req(stl_w[1])
`ifdef STALL_STATS_EN
    , .stall_count(scnt_w[1])
`endif
  );

  // Reference model: each DUT is a list of three instruction records
  // (EX, MEM, WB) plus the number of stall cycles still owed.
  typedef struct {
    bit v;
    int rd;
    int rt;
    bit rw;
    bit mr;
  } ins_t;

  ins_t pipe [2][3];
  int   owed [2];
  int   lat  [2] = '{1, 3};
  int   nstl [2];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  function automatic int dest(input ins_t s);
    return (s.v && s.rw && s.rd != 0) ? s.rd : 0;
  endfunction

  function automatic bit m_stall(input int k);
    ins_t x;
    bit   hz;
    if (owed[k] > 0) return !flush_x;
    x  = pipe[k][0];
    hz = d_valid && x.v && x.mr && x.rd != 0 &&
         (x.rd == int'(d_rs) || (d_uses_rt && x.rd == int'(d_rt)));
    return hz && !flush_x;
  endfunction

  task automatic m_reset();
    ins_t b;
    b = '{v: 0, rd: 0, rt: 0, rw: 0, mr: 0};
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 3; s++) pipe[k][s] = b;
      owed[k] = 0;
      nstl[k] = 0;
    end
  endtask

  task automatic m_tick(input int k);
    bit   st;
    ins_t n;
    st = m_stall(k);
    n  = '{v: 0, rd: 0, rt: 0, rw: 0, mr: 0};
    if (d_valid && !st && !flush_x)
      n = '{v: 1, rd: int'(d_rd), rt: int'(d_rt), rw: d_regwrite,
            mr: d_memread};
    pipe[k][2] = pipe[k][1];
    pipe[k][1] = pipe[k][0];
    pipe[k][0] = n;
    if (st && nstl[k] < 65535) nstl[k]++;
    if (flush_x) owed[k] = 0;
    else if (owed[k] > 0) owed[k]--;
    else if (st) owed[k] = lat[k] - 1;
  endtask

  task automatic m_check(input int k);
    string p;
    p = $sformatf("u%0d.", k);
    chk({p, "x_valid"}, x_v_w[k], pipe[k][0].v);
    chk({p, "x_rd"}, x_rd_w[k], dest(pipe[k][0]));
    chk({p, "x_rt"}, x_rt_w[k], pipe[k][0].v ? pipe[k][0].rt : 0);
    chk({p, "m_valid"}, m_v_w[k], pipe[k][1].v);
    chk({p, "m_rd"}, m_rd_w[k], dest(pipe[k][1]));
    chk({p, "w_rd"}, w_rd_w[k], dest(pipe[k][2]));
    chk({p, "w_regwrite"}, w_rw_w[k], dest(pipe[k][2]) != 0);
`ifdef STALL_STATS_EN
    chk({p, "stall_count"}, scnt_w[k], nstl[k]);
`endif
  endtask

  // kind: 0 directed row, 1 reset, 2 stall-count check, 3 random
  typedef struct {
    int kind;
    int u;
    bit v;
    int rs, rt;
    bit ur;
    int rd;
    bit rw, mr, fl;
    bit es;
    bit exv;
    int exrd, exrt, emrd, ewrd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t V(int u, bit v, int rs, int rt, bit ur, int rd,
                             bit rw, bit mr, bit fl, bit es, bit exv,
                             int exrd, int exrt, int emrd, int ewrd);
    vec_t r;
    r = '{kind: 0, u: u, v: v, rs: rs, rt: rt, ur: ur, rd: rd, rw: rw,
          mr: mr, fl: fl, es: es, exv: exv, exrd: exrd, exrt: exrt,
          emrd: emrd, ewrd: ewrd};
    return r;
  endfunction

  function automatic vec_t K(int kind);
    vec_t r;
    r = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    r.kind = kind;
    return r;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("rst.x_valid", x_v_w[k], 0);
      chk("rst.x_rd", x_rd_w[k], 0);
      chk("rst.x_rt", x_rt_w[k], 0);
      chk("rst.m_rd", m_rd_w[k], 0);
      chk("rst.m_valid", m_v_w[k], 0);
      chk("rst.w_rd", w_rd_w[k], 0);
      chk("rst.w_regwrite", w_rw_w[k], 0);
      chk("rst.stall_req", stl_w[k], 0);
`ifdef STALL_STATS_EN
      chk("rst.stall_count", scnt_w[k], 0);
`endif
    end
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic step(input vec_t r);
    d_valid    = r.v;
    d_rs       = 5'(r.rs);
    d_rt       = 5'(r.rt);
    d_uses_rt  = r.ur;
    d_rd       = 5'(r.rd);
    d_regwrite = r.rw;
    d_memread  = r.mr;
    flush_x    = r.fl;
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      chk($sformatf("u%0d.stall_req", k), stl_w[k], m_stall(k));
    if (r.kind == 0) chk("tbl.stall_req", stl_w[r.u], r.es);
    @(posedge clk);
    for (int k = 0; k < 2; k++) m_tick(k);
    #1;
    for (int k = 0; k < 2; k++) m_check(k);
    if (r.kind == 0) begin
      chk("tbl.x_valid", x_v_w[r.u], r.exv);
      chk("tbl.x_rd", x_rd_w[r.u], r.exrd);
      chk("tbl.x_rt", x_rt_w[r.u], r.exrt);
      chk("tbl.m_rd", m_rd_w[r.u], r.emrd);
      chk("tbl.w_rd", w_rd_w[r.u], r.ewrd);
    end
  endtask

  initial begin
    vec_t r;
    rst_n = 1'b0; d_valid = 0; d_rs = 0; d_rt = 0; d_uses_rt = 0;
    d_rd = 0; d_regwrite = 0; d_memread = 0; flush_x = 0;

    // three independent ALU ops
    tbl.push_back(K(1));
    tbl.push_back(V(0,1,1,2,1,8,1,0,0, 0,1,8,2,0,0));
    tbl.push_back(V(0,1,1,2,1,9,1,0,0, 0,1,9,2,8,0));
    tbl.push_back(V(0,1,1,2,1,10,1,0,0, 0,1,10,2,9,8));
    tbl.push_back(V(0,0,0,0,0,0,0,0,0, 0,0,0,0,10,9));
    tbl.push_back(V(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,10));
    // LOAD_LAT=1 load-use
    tbl.push_back(K(1));
    tbl.push_back(V(0,1,1,5,0,5,1,1,0, 0,1,5,5,0,0));
    tbl.push_back(V(0,1,5,2,1,11,1,0,0, 1,0,0,0,5,0));
    tbl.push_back(V(0,1,5,2,1,11,1,0,0, 0,1,11,2,0,5));
    tbl.push_back(V(0,0,0,0,0,0,0,0,0, 0,0,0,0,11,0));
    // LOAD_LAT=3 load then sw on rt, twice
    tbl.push_back(K(1));
    for (int n = 0; n < 2; n++) begin
      tbl.push_back(V(1,1,1,7,0,7,1,1,0, 0,1,7,7,0,0));
      tbl.push_back(V(1,1,1,7,1,0,0,0,0, 1,0,0,0,7,0));
      tbl.push_back(V(1,1,1,7,1,0,0,0,0, 1,0,0,0,0,7));
      tbl.push_back(V(1,1,1,7,1,0,0,0,0, 1,0,0,0,0,0));
      tbl.push_back(V(1,1,1,7,1,0,0,0,0, 0,1,0,7,0,0));
    end
    tbl.push_back(K(2));
    // addi ignores rt; load to $zero
    tbl.push_back(K(1));
    tbl.push_back(V(1,1,1,7,0,7,1,1,0, 0,1,7,7,0,0));
    tbl.push_back(V(1,1,3,7,0,12,1,0,0, 0,1,12,7,7,0));
    tbl.push_back(V(1,1,1,0,0,0,1,1,0, 0,1,0,0,12,7));
    tbl.push_back(V(1,1,0,2,1,13,1,0,0, 0,1,13,2,0,12));
    // flush in 2nd stall cycle, then flush colliding with detection
    tbl.push_back(K(1));
    tbl.push_back(V(1,1,1,7,0,7,1,1,0, 0,1,7,7,0,0));
    tbl.push_back(V(1,1,7,2,1,14,1,0,0, 1,0,0,0,7,0));
    tbl.push_back(V(1,1,7,2,1,14,1,0,1, 0,0,0,0,0,7));
    tbl.push_back(V(1,1,1,2,1,15,1,0,0, 0,1,15,2,0,0));
    tbl.push_back(V(1,1,1,7,0,7,1,1,0, 0,1,7,7,15,0));
    tbl.push_back(V(1,1,7,2,1,16,1,0,1, 0,0,0,0,7,15));
    tbl.push_back(V(1,1,7,2,1,16,1,0,0, 0,1,16,2,0,7));

    foreach (tbl[i]) begin
      if (tbl[i].kind == 1) begin
        do_reset();
      end else if (tbl[i].kind == 2) begin
`ifdef STALL_STATS_EN
        chk("stats.two_stalls", scnt_w[1], 6);
`endif
      end else begin
        step(tbl[i]);
      end
    end

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        r      = K(3);
        r.v    = $urandom_range(0, 9) < 8;
        r.rs   = $urandom_range(0, 3);
        r.rt   = $urandom_range(0, 3);
        r.ur   = $urandom_range(0, 1);
        r.rd   = $urandom_range(0, 3);
        r.rw   = $urandom_range(0, 3) != 0;
        r.mr   = $urandom_range(0, 9) < 4;
        r.fl   = $urandom_range(0, 9) == 0;
        step(r);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_rd_tracker.md
Name: pipe_rd_tracker

Overview:
- Tracks the destination register, valid, regwrite and memread attributes of the instructions in the EX, MEM and WB stages of the 5-stage MIPS pipeline.
- Drives the Xrd/Mrd/Xrt fields consumed by the Hazard unit.
- Sits between decode and the hazard/forwarding logic.
- Owns load-use stall sequencing: detects a load in EX feeding the instruction in D, raises stall_req for LOAD_LAT cycles, and inserts bubbles into EX.

Parameters:
- REG_W, 5, register-index width.
- LOAD_LAT, 1, stall cycles per load-use hazard. Legal range 1..7.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- d_valid  in  1  instruction in D is real, not a bubble.
- d_rs  in  REG_W  D source register rs.
- d_rt  in  REG_W  D source register rt.
- d_uses_rt  in  1  D instruction reads rt. Stores and R-type set it; I-type ALU ops and loads clear it.
- d_rd  in  REG_W  D destination register, already muxed rt/rd.
- d_regwrite  in  1  D instruction writes the register file.
- d_memread  in  1  D instruction is a load.
- flush_x  in  1  squash the D instruction instead of advancing it (branch/jump redirect).
- x_rd  out  REG_W  EX destination; 0 if EX is invalid or non-writing.
- x_rt  out  REG_W  EX rt field, used for the MEM-to-MEM store-data forward; 0 if EX is invalid.
- x_valid  out  1  EX slot valid.
- m_rd  out  REG_W  MEM destination; 0 if MEM is invalid or non-writing.
- m_valid  out  1  MEM slot valid.
- w_rd  out  REG_W  WB destination; 0 if WB is invalid or non-writing.
- w_regwrite  out  1  WB writes the register file.
- stall_req  out  1  hold PC and IF/ID, drives stallIF/stallD.

Behaviour:
- Reset, asynchronous on rst_n low:
  - All slots become bubbles: valid=0, rd=0, rt=0, regwrite=0, memread=0.
  - FSM goes to RUN; counter = 0.
  - All outputs read 0.
  - Reset mid-stall abandons the stall immediately.
- Bubble definition: valid=0, rd=0, rt=0, regwrite=0, memread=0.
- A captured instruction with d_rd==0 is stored with regwrite=0; $zero is never a forwarding source.
- Shift per clock edge: W<=M and M<=X every cycle, unconditionally.
- X capture: X<=D when d_valid & ~flush_x & ~stall_req; otherwise X<=bubble.
- Hazard term, combinational: hz = d_valid & x_valid & x_memread & (x_rd_reg!=0) & ((x_rd_reg==d_rs) | (d_uses_rt & (x_rd_reg==d_rt))).
- FSM states RUN and STALL; 3-bit counter cnt.
  - RUN: stall_req = hz & ~flush_x.
    - If stall_req and LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-1.
    - Otherwise stay in RUN.
  - STALL: stall_req = ~flush_x.
    - If flush_x, go to RUN with cnt=0 (flush aborts the stall).
    - Else if cnt==1, go to RUN.
    - Else cnt decrements.
- Net effect: stall_req is high for exactly LOAD_LAT consecutive cycles, starting in the detection cycle. One bubble enters EX per stall cycle. D is held by upstream, so after the last stall cycle the dependent instruction enters EX.
- Simultaneous flush_x and hz: flush wins; no stall, and a bubble enters EX.
- Back-to-back hazard: a second load-use detected in the cycle right after the stall ends restarts the sequence from RUN normally.
- Latency: D attributes appear on x_* one cycle after capture, m_* two cycles after, w_* three cycles after.
- Outputs are registered slot contents gated by the valid and regwrite flags; no combinational path from d_* to x_*, m_* or w_*. The single exception is stall_req, which is combinational from d_* and flush_x.

Optional Feature:
- Macro: STALL_STATS_EN.
- Defined: adds output stall_count [15:0].
  - Increments on every cycle where stall_req=1.
  - Saturates at 16'hFFFF.
  - Cleared by rst_n.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset then three independent ALU ops with rd=8, 9, 10:
  - x_rd reads 8, 9, 10 on consecutive cycles.
  - m_rd lags by 1 and w_rd by 2.
  - stall_req stays 0.
- LOAD_LAT=1, load rd=5 followed by an add with rs=5:
  - stall_req=1 for exactly 1 cycle.
  - Next cycle x_valid=0 and x_rd=0, while m_rd=5.
  - Following cycle x_rd = the add's rd.
- LOAD_LAT=3, load rd=7 followed by sw with d_uses_rt=1, rt=7:
  - stall_req high for 3 cycles.
  - 3 bubbles enter EX.
  - The store reaches EX on the 4th cycle.
- Load rd=7 followed by addi with rs=3, rt=7 and d_uses_rt=0: no stall.
- Load rd=0 followed by a consumer with rs=0: no stall; x_rd=0 while the load is in EX.
- LOAD_LAT=3 stall in progress, flush_x asserted in the 2nd stall cycle:
  - stall_req drops to 0 that cycle.
  - FSM is in RUN next cycle.
  - A bubble enters EX.
- With STALL_STATS_EN defined, the two load-use stalls of the LOAD_LAT=3 test give stall_count=6.
